// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared definitions for the data-memory arbiter.
// Holds the access-size codes, the selected-request payload, the
// load-owner tag and small helpers for size decoding and lane alignment.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef struct packed {
        logic              we;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_t;

    // Undefined size codes behave as a full-word access.
    function automatic logic [2:0] norm_size(input logic [2:0] size);
        case (size)
            SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU: norm_size = size;
            default:                                  norm_size = SIZE_W;
        endcase
    endfunction

    // Byte-lane offset truncated to the natural alignment of the size.
    function automatic logic [1:0] align_off(input logic [2:0] size, input logic [1:0] a);
        case (size)
            SIZE_B, SIZE_BU: align_off = a;
            SIZE_H, SIZE_HU: align_off = {a[1], 1'b0};
            default:         align_off = 2'b00;
        endcase
    endfunction

    // True when the address is not naturally aligned for the (normalised) size.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] a);
        case (size)
            SIZE_B, SIZE_BU: is_misaligned = 1'b0;
            SIZE_H, SIZE_HU: is_misaligned = a[0];
            default:         is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one direction.
//   STORE_DIR=1: be   = size mask shifted to the lane offset,
//                dout = din shifted left by 8*off.
//   STORE_DIR=0: dout = din shifted right by 8*off, then sign/zero
//                extended by size; be is unused (0).
// Ports: size (normalised size code), off (aligned lane offset),
//        din (store data or memory read word), be, dout.
module dmem_lane_align
    import dmem_arbiter_pkg::*;
#(
    parameter bit STORE_DIR = 1'b1
) (
    input  logic [2:0]        size,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] din,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] shifted;

    always_comb begin : lane_steer
        be      = 4'b0000;
        dout    = '0;
        shifted = din >> {off, 3'b000};
        if (STORE_DIR) begin
            dout = din << {off, 3'b000};
            case (size)
                SIZE_B, SIZE_BU: be = 4'b0001 << off;
                SIZE_H, SIZE_HU: be = 4'b0011 << off;
                default:         be = 4'b1111;
            endcase
        end else begin
            case (size)
                SIZE_B:  dout = {{24{shifted[7]}}, shifted[7:0]};
                SIZE_BU: dout = {24'h000000, shifted[7:0]};
                SIZE_H:  dout = {{16{shifted[15]}}, shifted[15:0]};
                SIZE_HU: dout = {16'h0000, shifted[15:0]};
                default: dout = shifted;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM
// stage (port 0) and the loader/debug port (port 1). One grant per cycle,
// fixed priority to port 0 unless port 1 has waited MAX_WAIT cycles.
// Stores write in the grant cycle; loads return extended data one cycle
// later on the port that issued them.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN adds p0_err/p1_err and
// turns misaligned accesses into an error response instead of truncating.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pN_req/we/size/addr/wdata     request from port N (held until pN_gnt)
//   pN_gnt                        request accepted this cycle
//   pN_rvalid/pN_rdata            load return pulse and extended data
//   pN_err                        misaligned-access response (macro only)
//   mem_we/be/addr/wdata          data_memory write side, word address
//   mem_rdata                     data_memory read word, one cycle latency
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [2:0]            p0_size,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [2:0]            p1_size,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic                  p0_err,
    output logic                  p1_err,
`endif
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rvalid_q, rvalid_d;
    owner_t            owner_q, owner_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;

    mem_req_t          req_c;
    logic              gnt_c;
    logic [2:0]        size_n_c;
    logic [1:0]        off_n_c;
    logic              trap_c;
    logic              rdata_ok_c;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        ld_be_unused;
    logic [DATA_W-1:0] ld_data;

    // Port 0 wins unless port 1 has been denied MAX_WAIT consecutive cycles.
    always_comb begin : arbitrate
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p1_req && (wait_cnt_q == CNT_W'(MAX_WAIT))) begin
                p1_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    // Saturating count of consecutive port-1 denials.
    always_comb begin : wait_count
        wait_cnt_d = wait_cnt_q;
        if (!p1_req || p1_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Mux the granted port's request and decode its size/lane.
    always_comb begin : select_request
        req_c.we    = p1_gnt ? p1_we : p0_we;
        req_c.size  = p1_gnt ? p1_size : p0_size;
        req_c.addr  = p1_gnt ? ADDR_W'(p1_addr) : ADDR_W'(p0_addr);
        req_c.wdata = p1_gnt ? DATA_W'(p1_wdata) : DATA_W'(p0_wdata);
        gnt_c       = p0_gnt | p1_gnt;
        size_n_c    = norm_size(req_c.size);
        off_n_c     = align_off(size_n_c, req_c.addr[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        trap_c      = is_misaligned(size_n_c, req_c.addr[1:0]);
`else
        trap_c      = 1'b0;
`endif
    end

    dmem_lane_align #(.STORE_DIR(1'b1)) u_store_align (
        .size (size_n_c),
        .off  (off_n_c),
        .din  (req_c.wdata),
        .be   (st_be),
        .dout (st_wdata)
    );

    // Memory write side; a trapped access never reaches the array.
    always_comb begin : mem_drive
        mem_we    = gnt_c && req_c.we && !trap_c;
        mem_be    = mem_we ? st_be : 4'b0000;
        mem_addr  = ADDR_WIDTH'({req_c.addr[ADDR_W-1:2], 2'b00});
        mem_wdata = DATA_WIDTH'(st_wdata);
    end

    // Remember who gets the response next cycle (loads and trapped accesses).
    always_comb begin : load_track
        rvalid_d = gnt_c && (!req_c.we || trap_c);
        owner_d  = p1_gnt ? OWN_P1 : OWN_P0;
        size_d   = size_n_c;
        off_d    = off_n_c;
    end

    always_ff @(posedge clk) begin : state_regs
        if (rst) begin
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            owner_q    <= OWN_P0;
            size_q     <= SIZE_W;
            off_q      <= 2'b00;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
            owner_q    <= owner_d;
            size_q     <= size_d;
            off_q      <= off_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q, err_d;

    always_comb begin : err_next
        err_d = gnt_c && trap_c;
    end

    always_ff @(posedge clk) begin : err_reg
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    dmem_lane_align #(.STORE_DIR(1'b0)) u_load_align (
        .size (size_q),
        .off  (off_q),
        .din  (DATA_W'(mem_rdata)),
        .be   (ld_be_unused),
        .dout (ld_data)
    );

    // Route the response to its owner; reset masks any in-flight return.
    always_comb begin : read_return
        p0_rvalid  = !rst && rvalid_q && (owner_q == OWN_P0);
        p1_rvalid  = !rst && rvalid_q && (owner_q == OWN_P1);
        rdata_ok_c = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        rdata_ok_c = !err_q;
        p0_err     = p0_rvalid && err_q;
        p1_err     = p1_rvalid && err_q;
`endif
        p0_rdata   = (p0_rvalid && rdata_ok_c) ? DATA_WIDTH'(ld_data) : '0;
        p1_rdata   = (p1_rvalid && rdata_ok_c) ? DATA_WIDTH'(ld_data) : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a byte-level
// memory reference model, a directed vector table, hand-written multi-cycle
// sequences and a randomized phase.
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT = 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic        req;
        logic        we;
        logic [2:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } port_in_t;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [2:0]  p0_size = 3'b0, p1_size = 3'b0;
    logic [7:0]  p0_addr = 8'h0, p1_addr = 8'h0;
    logic [31:0] p0_wdata = 32'h0, p1_wdata = 32'h0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_err, p1_err;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] bmem [64];
    logic [7:0]  ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference-model state.
    int          m_wcnt = 0;
    bit          pend_v = 1'b0, pend_own = 1'b0, pend_err = 1'b0;
    logic [31:0] pend_data = 32'h0;
    bit          last_g0 = 1'b0, last_g1 = 1'b0;

    // Values observed in the most recent cycle.
    logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_we, obs_err0;
    logic [3:0]  obs_be;
    logic [7:0]  obs_addr;
    logic [31:0] obs_wdata, obs_rd0, obs_rd1;

    dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_size   (p0_size),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_size   (p1_size),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
`ifdef DMEM_MISALIGN_TRAP_EN
        .p0_err    (p0_err),
        .p1_err    (p1_err),
`endif
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

`ifndef DMEM_MISALIGN_TRAP_EN
    assign p0_err = 1'b0;
    assign p1_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Single-port data memory: registered read, byte-enabled write.
    always @(posedge clk) begin : data_memory
        logic [31:0] w;
        mem_rdata <= bmem[mem_addr[7:2]];
        if (mem_we) begin
            w = bmem[mem_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            bmem[mem_addr[7:2]] <= w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] size);
        case (size)
            3'b000, 3'b100: nbytes = 1;
            3'b001, 3'b101: nbytes = 2;
            default:        nbytes = 4;
        endcase
    endfunction

    function automatic port_in_t mk(input logic we, input logic [2:0] size,
                                    input logic [7:0] addr, input logic [31:0] wdata);
        port_in_t p;
        p.req = 1'b1; p.we = we; p.size = size; p.addr = addr; p.wdata = wdata;
        return p;
    endfunction

    function automatic port_in_t rand_req(input int pct);
        port_in_t p;
        p.req   = ($urandom_range(0, 99) < pct);
        p.we    = ($urandom_range(0, 2) == 0);
        p.size  = p.we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        p.addr  = 8'($urandom);
        p.wdata = $urandom;
        return p;
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic run_cycle(input bit r, input port_in_t a0, input port_in_t a1);
        bit              g0, g1, mis, e0, e1, exp_we;
        port_in_t        s;
        int              n, base, lane;
        longint unsigned v;
        logic [3:0]      exp_be;
        logic [31:0]     exp_rd;
        @(negedge clk);
        rst = r;
        p0_req = a0.req; p0_we = a0.we; p0_size = a0.size; p0_addr = a0.addr; p0_wdata = a0.wdata;
        p1_req = a1.req; p1_we = a1.we; p1_size = a1.size; p1_addr = a1.addr; p1_wdata = a1.wdata;
        #1;
        // Response for whatever was granted last cycle.
        e0 = !r && pend_v && !pend_own;
        e1 = !r && pend_v && pend_own;
        exp_rd = pend_err ? 32'h0 : pend_data;
        chk("p0_rvalid", 32'(p0_rvalid), 32'(e0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(e1));
        chk("p0_rdata", p0_rdata, e0 ? exp_rd : 32'h0);
        chk("p1_rdata", p1_rdata, e1 ? exp_rd : 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("p0_err", 32'(p0_err), 32'(e0 && pend_err));
        chk("p1_err", 32'(p1_err), 32'(e1 && pend_err));
`endif
        obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid;
        obs_rd0 = p0_rdata; obs_rd1 = p1_rdata; obs_we = mem_we; obs_be = mem_be;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_err0 = p0_err;

        g0 = 1'b0; g1 = 1'b0;
        if (!r) begin
            if (a1.req && m_wcnt == MAX_WAIT) g1 = 1'b1;
            else if (a0.req)                  g0 = 1'b1;
            else if (a1.req)                  g1 = 1'b1;
        end
        chk("p0_gnt", 32'(p0_gnt), 32'(g0));
        chk("p1_gnt", 32'(p1_gnt), 32'(g1));

        s = g1 ? a1 : a0;
        pend_v = 1'b0; pend_err = 1'b0; pend_own = g1; pend_data = 32'h0;
        if (g0 || g1) begin
            n      = nbytes(s.size);
            base   = int'(s.addr) - (int'(s.addr) % n);
            lane   = base % 4;
            mis    = TRAP && ((int'(s.addr) % n) != 0);
            exp_we = s.we && !mis;
            exp_be = exp_we ? 4'(((1 << n) - 1) << lane) : 4'h0;
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_be", 32'(mem_be), 32'(exp_be));
            if (!mis) chk("mem_addr", 32'(mem_addr), 32'(s.addr & 8'hFC));
            if (exp_we) begin
                chk("mem_wdata", mem_wdata, 32'({32'h0, s.wdata} << (8 * lane)));
                for (int i = 0; i < n; i++) ref_mem[base + i] = s.wdata[8*i +: 8];
            end
            if (!s.we || mis) begin
                pend_v   = 1'b1;
                pend_err = mis;
                v = 64'h0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_mem[base + i]) << (8 * i));
                if ((s.size == 3'b000 || s.size == 3'b001) && v[8*n-1])
                    v = v | ~((64'd1 << (8 * n)) - 64'd1);
                pend_data = v[31:0];
            end
        end else begin
            chk("idle_mem_we", 32'(mem_we), 32'h0);
            chk("idle_mem_be", 32'(mem_be), 32'h0);
        end

        if (r)                     m_wcnt = 0;
        else if (a1.req && !g1)    m_wcnt = (m_wcnt < MAX_WAIT) ? m_wcnt + 1 : MAX_WAIT;
        else                       m_wcnt = 0;
        last_g0 = g0;
        last_g1 = g1;
    endtask

    initial begin : stimulus
        port_in_t    idle, q0, q1;
        vec_t        vt [11];
        logic [31:0] pre;
        bit          r;
        idle = '0;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++)
            bmem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};

        vt[0]  = '{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b0, 3'b000, 8'h13, 32'h0, 4'h0, 8'h10, 32'h0, 32'hFFFFFFDE};
        vt[2]  = '{1'b0, 3'b100, 8'h13, 32'h0, 4'h0, 8'h10, 32'h0, 32'h000000DE};
        vt[3]  = '{1'b0, 3'b101, 8'h12, 32'h0, 4'h0, 8'h10, 32'h0, 32'h0000DEAD};
        vt[4]  = '{1'b0, 3'b001, 8'h10, 32'h0, 4'h0, 8'h10, 32'h0, 32'hFFFFBEEF};
        vt[5]  = '{1'b1, 3'b000, 8'h21, 32'h000000AB, 4'h2, 8'h20, 32'h0000AB00, 32'h0};
        vt[6]  = '{1'b0, 3'b100, 8'h21, 32'h0, 4'h0, 8'h20, 32'h0, 32'h000000AB};
        vt[7]  = '{1'b1, 3'b001, 8'h26, 32'h00008001, 4'hC, 8'h24, 32'h80010000, 32'h0};
        vt[8]  = '{1'b0, 3'b001, 8'h26, 32'h0, 4'h0, 8'h24, 32'h0, 32'hFFFF8001};
        vt[9]  = '{1'b0, 3'b010, 8'h10, 32'h0, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF};
        vt[10] = '{1'b0, 3'b011, 8'h10, 32'h0, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF};

        // Reset with both ports requesting: nothing may be granted.
        run_cycle(1'b1, mk(1'b0, 3'b010, 8'h10, 32'h0), mk(1'b1, 3'b010, 8'h14, 32'h1));
        chk("reset_p0_gnt", 32'(obs_g0), 32'h0);
        chk("reset_p1_gnt", 32'(obs_g1), 32'h0);
        chk("reset_mem_we", 32'(obs_we), 32'h0);
        chk("reset_rvalid", 32'({obs_rv0, obs_rv1}), 32'h0);
        run_cycle(1'b1, idle, idle);

        // Directed vector table on port 0.
        foreach (vt[i]) begin
            run_cycle(1'b0, mk(vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata), idle);
            chk("tbl_gnt", 32'(obs_g0), 32'h1);
            chk("tbl_we", 32'(obs_we), 32'(vt[i].we));
            chk("tbl_be", 32'(obs_be), 32'(vt[i].exp_be));
            chk("tbl_addr", 32'(obs_addr), 32'(vt[i].exp_addr));
            if (vt[i].we) chk("tbl_wdata", obs_wdata, vt[i].exp_wdata);
            run_cycle(1'b0, idle, idle);
            chk("tbl_rvalid", 32'(obs_rv0), 32'(!vt[i].we));
            if (!vt[i].we) chk("tbl_rdata", obs_rd0, vt[i].exp_rdata);
        end

        // Continuous contention: port 1 wins on the fifth cycle only.
        run_cycle(1'b0, idle, idle);
        for (int c = 1; c <= 9; c++) begin
            run_cycle(1'b0, mk(1'b0, 3'b010, 8'h10, 32'h0), mk(1'b0, 3'b010, 8'h14, 32'h0));
            chk("starve_p1_gnt", 32'(obs_g1), 32'(c == 5));
            chk("starve_p0_gnt", 32'(obs_g0), 32'(c != 5));
        end
        run_cycle(1'b0, idle, idle);

        // Back-to-back loads from different ports: responses in grant order.
        run_cycle(1'b0, mk(1'b0, 3'b010, 8'h10, 32'h0), idle);
        run_cycle(1'b0, idle, mk(1'b0, 3'b010, 8'h14, 32'h0));
        chk("b2b_first_p0", 32'({obs_rv0, obs_rv1}), 32'h2);
        run_cycle(1'b0, idle, idle);
        chk("b2b_second_p1", 32'({obs_rv0, obs_rv1}), 32'h1);

        // Load then store to the same word returns the old contents.
        pre = {ref_mem[8'h33], ref_mem[8'h32], ref_mem[8'h31], ref_mem[8'h30]};
        run_cycle(1'b0, mk(1'b0, 3'b010, 8'h30, 32'h0), idle);
        run_cycle(1'b0, mk(1'b1, 3'b010, 8'h30, 32'h12345678), idle);
        chk("ld_before_st", obs_rd0, pre);
        run_cycle(1'b0, mk(1'b0, 3'b010, 8'h30, 32'h0), idle);
        run_cycle(1'b0, idle, idle);
        chk("ld_after_st", obs_rd0, 32'h12345678);

        // Reset right after a load grant kills the response; held request re-arbitrates.
        run_cycle(1'b0, mk(1'b0, 3'b010, 8'h10, 32'h0), idle);
        run_cycle(1'b1, mk(1'b0, 3'b010, 8'h10, 32'h0), idle);
        chk("rst_kills_rvalid", 32'(obs_rv0), 32'h0);
        chk("rst_no_gnt", 32'(obs_g0), 32'h0);
        run_cycle(1'b0, mk(1'b0, 3'b010, 8'h10, 32'h0), idle);
        chk("regrant_after_rst", 32'(obs_g0), 32'h1);
        run_cycle(1'b0, idle, idle);
        chk("regrant_rdata", obs_rd0, 32'hDEADBEEF);

`ifdef DMEM_MISALIGN_TRAP_EN
        // Misaligned store: granted, no write, error response next cycle.
        run_cycle(1'b0, mk(1'b1, 3'b010, 8'h12, 32'hCAFEF00D), idle);
        chk("trap_gnt", 32'(obs_g0), 32'h1);
        chk("trap_we", 32'(obs_we), 32'h0);
        chk("trap_be", 32'(obs_be), 32'h0);
        run_cycle(1'b0, idle, idle);
        chk("trap_err", 32'(obs_err0), 32'h1);
        chk("trap_rvalid", 32'(obs_rv0), 32'h1);
        chk("trap_rdata", obs_rd0, 32'h0);
`endif

        // Randomized traffic against the reference model.
        q0 = '0;
        q1 = '0;
        for (int k = 0; k < 3000; k++) begin
            if (!(q0.req && !last_g0)) q0 = rand_req(70);
            if (!(q1.req && !last_g1)) q1 = rand_req(50);
            r = ($urandom_range(0, 199) == 0);
            run_cycle(r, q0, q1);
        end
        run_cycle(1'b0, idle, idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
